// File: rtl/lap_stopwatch_pkg.sv
// Shared types and helpers for the lap stopwatch: BCD digit type, prescaler
// terminal-count helper and the run-state encoding.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  // Terminal count of the prescaler: one tick every freq_mhz*1000*tick_ms cycles.
  function automatic int div_count(input int freq_mhz, input int tick_ms);
    return freq_mhz * 1000 * tick_ms - 1;
  endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Key-pulse inputs and display/status outputs of the lap stopwatch core.
// master drives the key pulses, slave is the stopwatch core.
interface lap_stopwatch_if
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int LAP_DEPTH = 8
);
  localparam int TW    = BCD_W * N_DIGITS;
  localparam int IDX_W = $clog2(LAP_DEPTH);

  logic             start_stop;
  logic             lap;
  logic             show_next;
  logic             clear;
  logic             running;
  logic [TW-1:0]    time_bcd;
  logic [TW-1:0]    lap_bcd;
  logic [IDX_W-1:0] lap_idx;
  logic [IDX_W:0]   lap_count;
  logic             lap_full;
  logic             ovf;

  modport master (
    output start_stop, lap, show_next, clear,
    input  running, time_bcd, lap_bcd, lap_idx, lap_count, lap_full, ovf
  );

  modport slave (
    input  start_stop, lap, show_next, clear,
    output running, time_bcd, lap_bcd, lap_idx, lap_count, lap_full, ovf
  );

endinterface

// File: rtl/lap_stopwatch_bcd_chain.sv
// N-digit ripple-carry BCD counter with synchronous clear and optional
// saturation at all-nines.
module bcd_chain
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic                      clr,
  input  logic                      sat,
  output logic [BCD_W*N_DIGITS-1:0] digits,
  output logic                      all_nines
);

  logic [BCD_W*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS:0]         w_carry;

  // w_carry[k] is set when every digit below k holds 9.
  // NOTE: always_comb assigns a default before the loop so no path leaves a bit unassigned (no latch).
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_carry[k+1] = w_carry[k] && (r_digits[BCD_W*k +: BCD_W] == bcd_t'(9));
    end
  end

  assign all_nines = w_carry[N_DIGITS];
  assign digits    = r_digits;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
    end else if (clr) begin
      r_digits <= '0;
    end else if (inc && !(sat && all_nines)) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (w_carry[k]) begin
          r_digits[BCD_W*k +: BCD_W] <= (r_digits[BCD_W*k +: BCD_W] == bcd_t'(9))
                                        ? bcd_t'(0)
                                        : r_digits[BCD_W*k +: BCD_W] + bcd_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch core: prescaler, run control, N-digit time counter and a
// bounded lap store with paging.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int FREQ_MHZ  = 50,
  parameter int TICK_MS   = 100,
  parameter int N_DIGITS  = 4,
  parameter int LAP_DEPTH = 8,
  parameter int WRAP      = 1
) (
  input  logic           clk,
  input  logic           reset,
  lap_stopwatch_if.slave sw
);

  localparam int              DIV    = div_count(FREQ_MHZ, TICK_MS);
  localparam int              PW     = $clog2(DIV + 1);
  localparam int              TW     = BCD_W * N_DIGITS;
  localparam int              IDX_W  = $clog2(LAP_DEPTH);
  localparam logic [IDX_W:0]  LAST_C = (IDX_W+1)'(LAP_DEPTH - 1);
  localparam logic            SAT    = (WRAP == 0);

  run_state_e       r_state;
  run_state_e       w_state_next;
  logic [PW-1:0]    r_presc;
  logic             r_ovf;
  logic [IDX_W:0]   r_lap_count;
  logic [IDX_W-1:0] r_lap_idx;
  logic             r_lap_full;
  logic [TW-1:0]    r_lap_bcd;
  logic [TW-1:0]    r_lap_mem [LAP_DEPTH];

  logic             w_running;
  logic             w_tick;
  logic             w_clr;
  logic             w_start;
  logic             w_lap_ok;
  logic             w_page;
  logic [IDX_W:0]   w_idx_inc;
  logic [IDX_W-1:0] w_idx_next;
  logic [TW-1:0]    w_digits;
  logic             w_all_nines;

  assign w_running = (r_state == ST_RUNNING);
  assign w_tick    = w_running && (r_presc == PW'(DIV));
  assign w_clr     = sw.clear && !w_running;
  assign w_start   = sw.start_stop && !w_running;
  assign w_lap_ok  = sw.lap && !r_lap_full && !w_clr;
  assign w_page    = sw.show_next && (r_lap_count != '0);
  assign w_idx_inc  = {1'b0, r_lap_idx} + (IDX_W+1)'(1);
  assign w_idx_next = (w_idx_inc == r_lap_count) ? '0 : w_idx_inc[IDX_W-1:0];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_STOPPED: if (sw.start_stop) w_state_next = ST_RUNNING;
      // A saturating overflow stops the watch as if start_stop had been pressed.
      ST_RUNNING: if (sw.start_stop || (SAT && w_tick && w_all_nines)) w_state_next = ST_STOPPED;
      default:    w_state_next = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_STOPPED;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_clr || w_start || w_tick) begin
      r_presc <= '0;
    end else if (w_running) begin
      r_presc <= r_presc + PW'(1);
    end
  end

  bcd_chain #(.N_DIGITS(N_DIGITS)) u_chain (
    .clk       (clk),
    .reset     (reset),
    .inc       (w_tick),
    .clr       (w_clr),
    .sat       (SAT),
    .digits    (w_digits),
    .all_nines (w_all_nines)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf       <= 1'b0;
      r_lap_count <= '0;
      r_lap_idx   <= '0;
      r_lap_full  <= 1'b0;
      r_lap_bcd   <= '0;
    end else begin
      if (w_clr)                    r_ovf <= 1'b0;
      else if (w_tick && w_all_nines) r_ovf <= 1'b1;

      // A new lap takes precedence over paging in the same cycle.
      if (w_clr) begin
        r_lap_count <= '0;
        r_lap_idx   <= '0;
        r_lap_full  <= 1'b0;
        r_lap_bcd   <= '0;
      end else if (w_lap_ok) begin
        r_lap_count <= r_lap_count + (IDX_W+1)'(1);
        r_lap_idx   <= r_lap_count[IDX_W-1:0];
        r_lap_full  <= (r_lap_count == LAST_C);
        r_lap_bcd   <= w_digits;
      end else if (w_page) begin
        r_lap_idx   <= w_idx_next;
        r_lap_bcd   <= r_lap_mem[w_idx_next];
      end
    end
  end

  // NOTE: the lap array has no reset; entries at or above lap_count are never read.
  always_ff @(posedge clk) begin
    if (w_lap_ok) r_lap_mem[r_lap_count[IDX_W-1:0]] <= w_digits;
  end

  assign sw.running   = w_running;
  assign sw.time_bcd  = w_digits;
  assign sw.lap_bcd   = r_lap_bcd;
  assign sw.lap_idx   = r_lap_idx;
  assign sw.lap_count = r_lap_count;
  assign sw.lap_full  = r_lap_full;
  assign sw.ovf       = r_ovf;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed scoreboard bench for lap_stopwatch: a 4-digit/4-lap instance plus
// two 1-digit instances for wrap and saturate overflow behaviour.
module tb_lap_stopwatch;

  logic clk;
  logic reset;

  lap_stopwatch_if #(.N_DIGITS(4), .LAP_DEPTH(4)) a_if ();
  lap_stopwatch_if #(.N_DIGITS(1), .LAP_DEPTH(2)) b_if ();
  lap_stopwatch_if #(.N_DIGITS(1), .LAP_DEPTH(2)) c_if ();

  lap_stopwatch #(.FREQ_MHZ(1), .TICK_MS(1), .N_DIGITS(4), .LAP_DEPTH(4), .WRAP(1)) u_a (
    .clk (clk), .reset (reset), .sw (a_if));
  lap_stopwatch #(.FREQ_MHZ(1), .TICK_MS(1), .N_DIGITS(1), .LAP_DEPTH(2), .WRAP(1)) u_b (
    .clk (clk), .reset (reset), .sw (b_if));
  lap_stopwatch #(.FREQ_MHZ(1), .TICK_MS(1), .N_DIGITS(1), .LAP_DEPTH(2), .WRAP(0)) u_c (
    .clk (clk), .reset (reset), .sw (c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_RUN, S_TIME, S_LBCD, S_LIDX, S_LCNT, S_LFULL, S_OVF,
    S_B_TIME, S_B_OVF, S_C_TIME, S_C_OVF, S_C_RUN
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m      = 0;  // posedges since the first start pulse

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_RUN:    return 32'(a_if.running);
      S_TIME:   return 32'(a_if.time_bcd);
      S_LBCD:   return 32'(a_if.lap_bcd);
      S_LIDX:   return 32'(a_if.lap_idx);
      S_LCNT:   return 32'(a_if.lap_count);
      S_LFULL:  return 32'(a_if.lap_full);
      S_OVF:    return 32'(a_if.ovf);
      S_B_TIME: return 32'(b_if.time_bcd);
      S_B_OVF:  return 32'(b_if.ovf);
      S_C_TIME: return 32'(c_if.time_bcd);
      S_C_OVF:  return 32'(c_if.ovf);
      S_C_RUN:  return 32'(c_if.running);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic want(input string tag, input sig_e sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      n_cmp++;
      assert (o === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    m += n;
  endtask

  task automatic goto(input int e);
    if (e > m) step(e - m);
  endtask

  task automatic pulse(input bit ss, input bit lp, input bit sn, input bit cl);
    a_if.start_stop = ss;
    a_if.lap        = lp;
    a_if.show_next  = sn;
    a_if.clear      = cl;
    step(1);
    a_if.start_stop = 1'b0;
    a_if.lap        = 1'b0;
    a_if.show_next  = 1'b0;
    a_if.clear      = 1'b0;
  endtask

  task automatic want_laps(input string tag, input int cnt, input int idx,
                           input int bcd, input bit full);
    want({tag, "_cnt"},  S_LCNT,  32'(cnt));
    want({tag, "_idx"},  S_LIDX,  32'(idx));
    want({tag, "_bcd"},  S_LBCD,  32'(bcd));
    want({tag, "_full"}, S_LFULL, 32'(full));
  endtask

  initial begin
    reset = 1'b1;
    {a_if.start_stop, a_if.lap, a_if.show_next, a_if.clear} = '0;
    {b_if.start_stop, b_if.lap, b_if.show_next, b_if.clear} = '0;
    {c_if.start_stop, c_if.lap, c_if.show_next, c_if.clear} = '0;

    @(negedge clk);
    want("rst_run", S_RUN, 0);
    want("rst_time", S_TIME, 0);
    want("rst_ovf", S_OVF, 0);
    want_laps("rst", 0, 0, 0, 0);
    check();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Paging with no laps stored is ignored.
    pulse(0, 0, 1, 0);
    want_laps("page_empty", 0, 0, 0, 0);
    check();

    // Start all three instances on the same edge (edge 0).
    m = -1;
    b_if.start_stop = 1'b1;
    c_if.start_stop = 1'b1;
    pulse(1, 0, 0, 0);
    b_if.start_stop = 1'b0;
    c_if.start_stop = 1'b0;
    want("start_run", S_RUN, 1);
    want("start_time", S_TIME, 0);
    check();

    // Ticks land on edges 1000*n; laps mid-interval capture a stable time.
    goto(3499); pulse(0, 1, 0, 0);
    want_laps("lap3", 1, 0, 32'h3, 0);
    want("lap3_time", S_TIME, 32'h3);
    check();
    goto(7499); pulse(0, 1, 0, 0);
    want_laps("lap7", 2, 1, 32'h7, 0);
    check();

    goto(9999);
    want("pre_wrap_a", S_TIME, 32'h0009);
    want("pre_wrap_b", S_B_TIME, 32'h9);
    want("pre_wrap_b_ovf", S_B_OVF, 0);
    want("pre_sat_c", S_C_TIME, 32'h9);
    want("pre_sat_c_ovf", S_C_OVF, 0);
    want("pre_sat_c_run", S_C_RUN, 1);
    check();
    step(1);
    want("carry_a", S_TIME, 32'h0010);
    want("carry_a_ovf", S_OVF, 0);
    want("wrap_b", S_B_TIME, 32'h0);
    want("wrap_b_ovf", S_B_OVF, 1);
    want("sat_c", S_C_TIME, 32'h9);
    want("sat_c_ovf", S_C_OVF, 1);
    want("sat_c_run", S_C_RUN, 0);
    check();

    goto(12499); pulse(0, 1, 0, 0);
    want_laps("lap12", 3, 2, 32'h12, 0);
    check();

    pulse(0, 0, 1, 0); want_laps("page1", 3, 0, 32'h3, 0);  check();
    pulse(0, 0, 1, 0); want_laps("page2", 3, 1, 32'h7, 0);  check();
    pulse(0, 0, 1, 0); want_laps("page3", 3, 2, 32'h12, 0); check();
    pulse(0, 0, 1, 0); want_laps("page4", 3, 0, 32'h3, 0);  check();

    // Lap and show_next together: the lap wins.
    goto(20499); pulse(0, 1, 1, 0);
    want_laps("lap20", 4, 3, 32'h20, 1);
    check();

    goto(25000);
    want("count25", S_TIME, 32'h0025);
    want("count25_run", S_RUN, 1);
    check();

    goto(25499); pulse(1, 0, 0, 0);
    want("stop_run", S_RUN, 0);
    want("stop_time", S_TIME, 32'h0025);
    check();
    goto(30500);
    want("stopped_hold", S_TIME, 32'h0025);
    check();

    pulse(0, 1, 0, 0);
    want_laps("lap_full_drop", 4, 3, 32'h20, 1);
    check();
    pulse(0, 0, 1, 0);
    want_laps("page_full_wrap", 4, 0, 32'h3, 1);
    check();

    // Clear while running is ignored.
    pulse(1, 0, 0, 0);
    goto(30599); pulse(0, 0, 0, 1);
    want("clr_run_time", S_TIME, 32'h0025);
    want("clr_run_run", S_RUN, 1);
    want_laps("clr_run", 4, 0, 32'h3, 1);
    check();

    // Clear + start_stop while stopped: cleared and running (edge 30602).
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 1);
    want("clr_start_time", S_TIME, 0);
    want("clr_start_run", S_RUN, 1);
    want("clr_start_ovf", S_OVF, 0);
    want_laps("clr_start", 0, 0, 0, 0);
    check();

    // Lap on the tick edge that takes time 9 to 10 stores 9.
    goto(40601); pulse(0, 1, 0, 0);
    want_laps("lap_tick", 1, 0, 32'h0009, 0);
    want("lap_tick_time", S_TIME, 32'h0010);
    check();

    // Lap + start_stop: lap recorded and the watch stops.
    goto(40999); pulse(1, 1, 0, 0);
    want_laps("lap_stop", 2, 1, 32'h0010, 0);
    want("lap_stop_run", S_RUN, 0);
    check();

    // Asynchronous reset between edges while running.
    pulse(1, 0, 0, 0);
    goto(41500);
    #2 reset = 1'b1;
    #1;
    want("arst_run", S_RUN, 0);
    want("arst_time", S_TIME, 0);
    want("arst_ovf", S_OVF, 0);
    want_laps("arst", 0, 0, 0, 0);
    want("arst_b_ovf", S_B_OVF, 0);
    want("arst_b_time", S_B_TIME, 0);
    want("arst_c_ovf", S_C_OVF, 0);
    check();
    @(negedge clk);
    reset = 1'b0;
    step(2000);
    want("post_rst_idle_time", S_TIME, 0);
    want("post_rst_idle_run", S_RUN, 0);
    check();

    pulse(1, 0, 0, 0);
    want("resume_run", S_RUN, 1);
    step(999);
    want("resume_pre_tick", S_TIME, 0);
    check();
    step(1);
    want("resume_tick", S_TIME, 32'h0001);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
